// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit four-register CPU front end.
package cpu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned REG_W   = 2;
  localparam int unsigned IMM_W   = 2;
  localparam int unsigned JOFF_W  = 6;

  localparam int unsigned OP_HI   = 7;
  localparam int unsigned OP_LO   = 6;
  localparam int unsigned RS_HI   = 5;
  localparam int unsigned RS_LO   = 4;
  localparam int unsigned RT_HI   = 3;
  localparam int unsigned RT_LO   = 2;
  localparam int unsigned RD_HI   = 1;
  localparam int unsigned RD_LO   = 0;
  localparam int unsigned JOFF_HI = 5;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_J   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  typedef struct packed {
    logic reg_write;
    logic reg_dst;
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    op_e               op;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] imm;
    ctrl_t             ctrl;
  } dec_t;

endpackage

// File: rtl/ifetch_decode_if.sv
// Instruction-memory and decoded-instruction bundle of the fetch/decode stage.
interface ifetch_decode_if #(
  parameter int unsigned CNT_W = 16
);
  logic [7:0]       Read_Address;
  logic [7:0]       Instruction;
  logic             Stall;
  logic             Inst_Valid;
  logic [1:0]       Op;
  logic [1:0]       Rs;
  logic [1:0]       Rt;
  logic [1:0]       Rd;
  logic [7:0]       Imm;
  logic             RegWrite;
  logic             RegDst;
  logic             ALUSrc;
  logic             MemRead;
  logic             MemWrite;
  logic             MemToReg;
  logic [7:0]       Inst_PC;
  logic             Halted;
  logic [CNT_W-1:0] Issue_Count;

  modport master (
    output Read_Address,
    input  Instruction,
    input  Stall,
    output Inst_Valid, Op, Rs, Rt, Rd, Imm,
    output RegWrite, RegDst, ALUSrc, MemRead, MemWrite, MemToReg,
    output Inst_PC, Halted, Issue_Count
  );

  modport slave (
    input  Read_Address,
    output Instruction,
    output Stall,
    input  Inst_Valid, Op, Rs, Rt, Rd, Imm,
    input  RegWrite, RegDst, ALUSrc, MemRead, MemWrite, MemToReg,
    input  Inst_PC, Halted, Issue_Count
  );
endinterface

// File: rtl/inst_decoder.sv
// Combinational byte-to-fields/strobes decoder; also exposes the jump offset.
module inst_decoder
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] inst,
  output dec_t              dec_c,
  output logic              is_jump_c,
  output logic [DATA_W-1:0] jump_off_c
);

  always_comb begin
    dec_c      = '0;
    is_jump_c  = 1'b0;
    jump_off_c = {{(DATA_W-JOFF_W){inst[JOFF_HI]}}, inst[JOFF_HI:0]};
    dec_c.op   = op_e'(inst[OP_HI:OP_LO]);
    dec_c.rs   = inst[RS_HI:RS_LO];
    dec_c.rt   = inst[RT_HI:RT_LO];
    // Low two bits are rd for add and a signed offset for memory ops.
    case (op_e'(inst[OP_HI:OP_LO]))
      OP_ADD: begin
        dec_c.rd             = inst[RD_HI:RD_LO];
        dec_c.ctrl.reg_write = 1'b1;
        dec_c.ctrl.reg_dst   = 1'b1;
      end
      OP_LW: begin
        dec_c.imm             = {{(DATA_W-IMM_W){inst[RD_HI]}}, inst[RD_HI:RD_LO]};
        dec_c.ctrl.reg_write  = 1'b1;
        dec_c.ctrl.alu_src    = 1'b1;
        dec_c.ctrl.mem_read   = 1'b1;
        dec_c.ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        dec_c.imm            = {{(DATA_W-IMM_W){inst[RD_HI]}}, inst[RD_HI:RD_LO]};
        dec_c.ctrl.alu_src   = 1'b1;
        dec_c.ctrl.mem_write = 1'b1;
      end
      OP_J:    is_jump_c = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ifetch_decode.sv
// Fetch/decode front end: PC, jump resolution, IR stage, halt detection, issue counter.
module ifetch_decode
  import cpu_pkg::*;
#(
  parameter logic [7:0]  PC_RESET = 8'h00,
  parameter int unsigned CNT_W    = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  ifetch_decode_if.master bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_pc_q, inst_pc_d;
  dec_t              dec_q, dec_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  dec_t              dec_c;
  logic              is_jump_c;
  logic [DATA_W-1:0] jump_off_c;
  logic [DATA_W-1:0] target_c;

  inst_decoder u_dec (
    .inst       (bus.Instruction),
    .dec_c      (dec_c),
    .is_jump_c  (is_jump_c),
    .jump_off_c (jump_off_c)
  );

  assign target_c = pc_q + DATA_W'(1) + jump_off_c;

  // Next-state, PC, IR and counter update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_pc_d = inst_pc_q;
    dec_d     = dec_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN: begin
        if (!bus.Stall) begin
          if (is_jump_c) begin
            valid_d    = 1'b0;
            dec_d.ctrl = '0;
            if (target_c == pc_q) begin
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end else begin
              pc_d = target_c;
            end
          end else begin
            dec_d     = dec_c;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + DATA_W'(1);
          end
        end
      end
      ST_HALT: begin
        if (!bus.Stall) begin
          valid_d    = 1'b0;
          dec_d.ctrl = '0;
        end
      end
      default: state_d = ST_RESET;
    endcase

    if (valid_q && !bus.Stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_RESET;
      pc_q      <= PC_RESET;
      inst_pc_q <= '0;
      dec_q     <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_pc_q <= inst_pc_d;
      dec_q     <= dec_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.Read_Address = pc_q;
  assign bus.Inst_Valid   = valid_q;
  assign bus.Op           = dec_q.op;
  assign bus.Rs           = dec_q.rs;
  assign bus.Rt           = dec_q.rt;
  assign bus.Rd           = dec_q.rd;
  assign bus.Imm          = dec_q.imm;
  assign bus.RegWrite     = dec_q.ctrl.reg_write;
  assign bus.RegDst       = dec_q.ctrl.reg_dst;
  assign bus.ALUSrc       = dec_q.ctrl.alu_src;
  assign bus.MemRead      = dec_q.ctrl.mem_read;
  assign bus.MemWrite     = dec_q.ctrl.mem_write;
  assign bus.MemToReg     = dec_q.ctrl.mem_to_reg;
  assign bus.Inst_PC      = inst_pc_q;
  assign bus.Halted       = halted_q;
  assign bus.Issue_Count  = cnt_q;

endmodule

// File: tb/tb_ifetch_decode.sv
// Self-checking bench: decode vector table, directed jump/stall/reset/wrap/saturation runs, random vs reference model.
module tb_ifetch_decode;

  typedef struct {
    logic [7:0] ins;
    logic [1:0] op;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] rd;
    logic [7:0] imm;
    logic [5:0] stb;
  } vec_t;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_checks;
  int   n_fail;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  vec_t       vt [8];

  ifetch_decode_if #(.CNT_W(16)) ifa ();
  ifetch_decode_if #(.CNT_W(4))  ifb ();

  ifetch_decode #(.PC_RESET(8'h00), .CNT_W(16)) u_a (.Clk(clk), .Reset(rst_a), .bus(ifa));
  ifetch_decode #(.PC_RESET(8'hFE), .CNT_W(4))  u_b (.Clk(clk), .Reset(rst_b), .bus(ifb));

  assign ifa.Instruction = mem_a[ifa.Read_Address];
  assign ifb.Instruction = mem_b[ifb.Read_Address];

  wire [5:0] stb_a = {ifa.RegWrite, ifa.RegDst, ifa.ALUSrc, ifa.MemRead, ifa.MemWrite, ifa.MemToReg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_reset_a(input string nm);
    chk({nm, "_ra"}, 32'(ifa.Read_Address), 32'h00);
    chk({nm, "_valid"}, 32'(ifa.Inst_Valid), 32'h0);
    chk({nm, "_halted"}, 32'(ifa.Halted), 32'h0);
    chk({nm, "_cnt"}, 32'(ifa.Issue_Count), 32'h0);
    chk({nm, "_fields"}, {8'h00, ifa.Op, ifa.Rs, ifa.Rt, ifa.Rd, ifa.Imm, ifa.Inst_PC}, 32'h0);
    chk({nm, "_stb"}, 32'(stb_a), 32'h0);
  endtask

  task automatic chk_valid_a(input string nm, input logic [7:0] ipc, input logic [7:0] ra, input logic [1:0] op);
    chk({nm, "_valid"}, 32'(ifa.Inst_Valid), 32'h1);
    chk({nm, "_ipc"}, 32'(ifa.Inst_PC), 32'(ipc));
    chk({nm, "_ra"}, 32'(ifa.Read_Address), 32'(ra));
    chk({nm, "_op"}, 32'(ifa.Op), 32'(op));
  endtask

  // Reference decode written from the encoding table.
  function automatic vec_t ref_dec(input logic [7:0] b);
    vec_t v;
    v.ins = b;
    v.op  = b[7:6];
    v.rs  = b[5:4];
    v.rt  = b[3:2];
    v.rd  = 2'd0;
    v.imm = 8'h00;
    v.stb = 6'b000000;
    case (b[7:6])
      2'b00: begin v.rd = b[1:0]; v.stb = 6'b110000; end
      2'b01: begin v.imm = b[1] ? (8'hFC | {6'b0, b[1:0]}) : {6'b0, b[1:0]}; v.stb = 6'b101101; end
      2'b10: begin v.imm = b[1] ? (8'hFC | {6'b0, b[1:0]}) : {6'b0, b[1:0]}; v.stb = 6'b001010; end
      default: ;
    endcase
    return v;
  endfunction

  // Behavioural model of DUT A: mode 0 = reset, 1 = running, 2 = halted.
  int         m_mode;
  logic [7:0] m_pc;
  logic [7:0] m_ipc;
  logic       m_valid;
  logic       m_halt;
  int         m_cnt;
  vec_t       m_exp;

  task automatic model_step(input logic rst, input logic stall);
    logic [7:0] b;
    int         off;
    int         tgt;
    bit         consumed;
    if (rst) begin
      m_mode = 0; m_pc = 8'h00; m_valid = 1'b0; m_halt = 1'b0; m_cnt = 0;
      return;
    end
    consumed = m_valid && !stall;
    b = mem_a[m_pc];
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (!stall) begin
      if (m_mode == 1) begin
        if (b[7:6] == 2'b11) begin
          off = b[5] ? int'(b[5:0]) - 64 : int'(b[5:0]);
          tgt = (int'(m_pc) + 1 + off) & 255;
          m_valid = 1'b0;
          if (tgt == int'(m_pc)) begin m_mode = 2; m_halt = 1'b1; end
          else m_pc = 8'(tgt);
        end else begin
          m_exp = ref_dec(b); m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 8'd1;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    if (consumed && m_cnt < 65535) m_cnt++;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.Stall = 1'b0;
    ifb.Stall = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'hFF;
      mem_b[i] = 8'h1B;
    end

    vt[0] = '{8'h50, 2'd1, 2'd1, 2'd0, 2'd0, 8'h00, 6'b101101};
    vt[1] = '{8'h59, 2'd1, 2'd1, 2'd2, 2'd0, 8'h01, 6'b101101};
    vt[2] = '{8'h18, 2'd0, 2'd1, 2'd2, 2'd0, 8'h00, 6'b110000};
    vt[3] = '{8'h99, 2'd2, 2'd1, 2'd2, 2'd0, 8'h01, 6'b001010};
    vt[4] = '{8'h6E, 2'd1, 2'd2, 2'd3, 2'd0, 8'hFE, 6'b101101};
    vt[5] = '{8'hA3, 2'd2, 2'd2, 2'd0, 2'd0, 8'hFF, 6'b001010};
    vt[6] = '{8'h27, 2'd0, 2'd2, 2'd1, 2'd3, 8'h00, 6'b110000};
    vt[7] = '{8'h81, 2'd2, 2'd0, 2'd0, 2'd0, 8'h01, 6'b001010};
    for (int i = 0; i < 8; i++) mem_a[i] = vt[i].ins;

    // Decode table, ending in a jump-to-self at address 8.
    tick();
    chk_reset_a("rst0");
    rst_a = 1'b0;
    tick();
    chk("run0_valid", 32'(ifa.Inst_Valid), 32'h0);
    chk("run0_ra", 32'(ifa.Read_Address), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_valid_a($sformatf("vec%0d", i), 8'(i), 8'(i + 1), vt[i].op);
      chk($sformatf("vec%0d_regs", i), {26'h0, ifa.Rs, ifa.Rt, ifa.Rd}, {26'h0, vt[i].rs, vt[i].rt, vt[i].rd});
      chk($sformatf("vec%0d_imm", i), 32'(ifa.Imm), 32'(vt[i].imm));
      chk($sformatf("vec%0d_stb", i), 32'(stb_a), 32'(vt[i].stb));
    end
    tick();
    chk("halt_valid", 32'(ifa.Inst_Valid), 32'h0);
    chk("halt_flag", 32'(ifa.Halted), 32'h1);
    chk("halt_ra", 32'(ifa.Read_Address), 32'h8);
    chk("halt_cnt", 32'(ifa.Issue_Count), 32'h8);
    chk("halt_stb", 32'(stb_a), 32'h0);
    tick();
    chk("halt2_ra", 32'(ifa.Read_Address), 32'h8);
    chk("halt2_cnt", 32'(ifa.Issue_Count), 32'h8);
    chk("halt2_flag", 32'(ifa.Halted), 32'h1);

    // Reset out of HALT, then a +3 jump from address 2.
    rst_a = 1'b1;
    tick();
    chk_reset_a("rst_halt");
    mem_a[0] = 8'h18; mem_a[1] = 8'h27; mem_a[2] = 8'hC3;
    mem_a[3] = 8'h50; mem_a[4] = 8'h50; mem_a[5] = 8'h50;
    mem_a[6] = 8'h99; mem_a[7] = 8'hFF;
    rst_a = 1'b0;
    tick();
    tick();
    chk_valid_a("j0", 8'h00, 8'h01, 2'd0);
    tick();
    chk_valid_a("j1", 8'h01, 8'h02, 2'd0);
    tick();
    chk("jb_valid", 32'(ifa.Inst_Valid), 32'h0);
    chk("jb_ra", 32'(ifa.Read_Address), 32'h6);
    chk("jb_stb", 32'(stb_a), 32'h0);
    chk("jb_halted", 32'(ifa.Halted), 32'h0);
    tick();
    chk_valid_a("j6", 8'h06, 8'h07, 2'd2);
    tick();
    chk("j_halt", 32'(ifa.Halted), 32'h1);
    chk("j_cnt", 32'(ifa.Issue_Count), 32'h3);

    // Stall holds the first lw; stall over a pending jump defers the halt.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    mem_a[0] = 8'h50; mem_a[1] = 8'h18; mem_a[2] = 8'hFF;
    tick();
    tick();
    chk_valid_a("s0", 8'h00, 8'h01, 2'd1);
    ifa.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_valid_a($sformatf("stall%0d", i), 8'h00, 8'h01, 2'd1);
      chk($sformatf("stall%0d_stb", i), 32'(stb_a), 32'b101101);
      chk($sformatf("stall%0d_cnt", i), 32'(ifa.Issue_Count), 32'h0);
    end
    ifa.Stall = 1'b0;
    tick();
    chk_valid_a("s1", 8'h01, 8'h02, 2'd0);
    chk("s1_cnt", 32'(ifa.Issue_Count), 32'h1);
    ifa.Stall = 1'b1;
    tick();
    chk_valid_a("sj", 8'h01, 8'h02, 2'd0);
    chk("sj_halted", 32'(ifa.Halted), 32'h0);
    ifa.Stall = 1'b0;
    tick();
    chk("sj2_halted", 32'(ifa.Halted), 32'h1);
    chk("sj2_valid", 32'(ifa.Inst_Valid), 32'h0);
    chk("sj2_cnt", 32'(ifa.Issue_Count), 32'h2);

    // Reset while stalled on a valid instruction.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    tick();
    tick();
    ifa.Stall = 1'b1;
    tick();
    rst_a = 1'b1;
    tick();
    chk_reset_a("rst_stall");
    rst_a = 1'b0;
    ifa.Stall = 1'b0;
    tick();
    tick();
    chk_valid_a("rs0", 8'h00, 8'h01, 2'd1);

    // PC wrap from FE and 4-bit counter saturation.
    rst_b = 1'b0;
    tick();
    chk("w_run_ra", 32'(ifb.Read_Address), 32'hFE);
    chk("w_run_valid", 32'(ifb.Inst_Valid), 32'h0);
    tick();
    chk("wFE_ipc", 32'(ifb.Inst_PC), 32'hFE);
    chk("wFE_ra", 32'(ifb.Read_Address), 32'hFF);
    tick();
    chk("wFF_ipc", 32'(ifb.Inst_PC), 32'hFF);
    chk("wFF_ra", 32'(ifb.Read_Address), 32'h00);
    tick();
    chk("w00_ipc", 32'(ifb.Inst_PC), 32'h00);
    chk("w00_ra", 32'(ifb.Read_Address), 32'h01);
    chk("w00_cnt", 32'(ifb.Issue_Count), 32'h2);
    repeat (20) tick();
    chk("sat_cnt", 32'(ifb.Issue_Count), 32'hF);
    tick();
    chk("sat2_cnt", 32'(ifb.Issue_Count), 32'hF);
    chk("sat2_valid", 32'(ifb.Inst_Valid), 32'h1);

    // Random program, stall and reset against the reference model.
    for (int i = 0; i < 256; i++) mem_a[i] = 8'($urandom);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic r;
      logic s;
      tick();
      if (cyc > 0) begin
        chk("rnd_ra", 32'(ifa.Read_Address), 32'(m_pc));
        chk("rnd_valid", 32'(ifa.Inst_Valid), 32'(m_valid));
        chk("rnd_halted", 32'(ifa.Halted), 32'(m_halt));
        chk("rnd_cnt", 32'(ifa.Issue_Count), 32'(m_cnt));
        if (m_valid) begin
          chk("rnd_ipc", 32'(ifa.Inst_PC), 32'(m_ipc));
          chk("rnd_fields", {14'h0, ifa.Op, ifa.Rs, ifa.Rt, ifa.Rd, ifa.Imm},
              {14'h0, m_exp.op, m_exp.rs, m_exp.rt, m_exp.rd, m_exp.imm});
          chk("rnd_stb", 32'(stb_a), 32'(m_exp.stb));
        end else begin
          chk("rnd_stb_idle", 32'(stb_a), 32'h0);
        end
      end
      r = (cyc == 0) || ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 30);
      rst_a = r;
      ifa.Stall = s;
      model_step(r, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
